bridge_ingress_arbiter: RTL

Frame-level round-robin arbiter that shares one 8-bit fifo_buff write port between two ingress byte streams (port A, port B) of the Ethernet bridge. Grants one port at a time for a whole frame, so bytes from different frames never interleave in the FIFO. Drives the FIFO write/data_in pins directly and propagates FIFO full as per-port backpressure. Reports per-frame completion (source port, length) and keeps per-port frame counters for the bridge control logic.

---
 rtl/bridge_ingress_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bridge_ingress_arbiter.sv
// bridge_ingress_arbiter
// Frame-level round-robin arbiter that shares one 8-bit fifo_buff write port
// between two ingress byte streams (port A, port B). A grant lasts for a whole
// frame, so bytes of different frames never interleave in the FIFO.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   en                          enable; low blocks new grants only
//   a_valid/a_data/a_last       port A byte stream, a_ready = accept
//   b_valid/b_data/b_last       port B byte stream, b_ready = accept
//   fifo_full                   full flag from fifo_buff (backpressure)
//   fifo_write/fifo_data        write strobe and data_in to fifo_buff
//   frame_done                  one-cycle pulse after a frame's last byte
//   done_port/done_len          source (0=A, 1=B) and length of that frame
//   overflow                    sticky, a frame exceeded 2^LEN_W-1 bytes
//   a_frames/b_frames           wrapping per-port completed-frame counters
module bridge_ingress_arbiter #(
  parameter int LEN_W = 11,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a_valid,
  input  logic [7:0]       a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [7:0]       b_data,
  input  logic             b_last,
  output logic             b_ready,
  input  logic             fifo_full,
  output logic             fifo_write,
  output logic [7:0]       fifo_data,
  output logic             frame_done,
  output logic             done_port,
  output logic [LEN_W-1:0] done_len,
  output logic             overflow,
  output logic [CNT_W-1:0] a_frames,
  output logic [CNT_W-1:0] b_frames
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t           state, state_nxt;
  logic             last_grant;   // 0 = A, 1 = B
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic             accept_last;
  logic             src_is_b;

  // Saturating increment: the count sticks at LEN_MAX once a frame runs long.
  assign cnt_inc  = (byte_cnt == LEN_MAX) ? LEN_MAX : LEN_W'(byte_cnt + 1'b1);
  assign src_is_b = (state == GNT_B);

  // Next-state and the zero-latency FIFO mux. Ready follows ~fifo_full
  // combinationally so the FIFO is never written while full.
  always_comb begin
    state_nxt   = state;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    fifo_write  = 1'b0;
    fifo_data   = 8'h00;
    accept_last = 1'b0;
    case (state)
      IDLE: begin
        // Grant is decided from this cycle's valids only; a tie goes to the
        // port that did not have the previous grant.
        if (en) begin
          if (a_valid && b_valid)
            state_nxt = last_grant ? GNT_A : GNT_B;
          else if (a_valid)
            state_nxt = GNT_A;
          else if (b_valid)
            state_nxt = GNT_B;
        end
      end
      GNT_A: begin
        a_ready     = ~fifo_full;
        fifo_write  = a_valid & ~fifo_full;
        fifo_data   = a_data;
        accept_last = a_valid & ~fifo_full & a_last;
        if (accept_last)
          state_nxt = IDLE;
      end
      GNT_B: begin
        b_ready     = ~fifo_full;
        fifo_write  = b_valid & ~fifo_full;
        fifo_data   = b_data;
        accept_last = b_valid & ~fifo_full & b_last;
        if (accept_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, byte counter and frame reporting. A reset mid-frame simply drops
  // the partial frame; nothing is reported for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      byte_cnt   <= '0;
      frame_done <= 1'b0;
      done_port  <= 1'b0;
      done_len   <= '0;
      overflow   <= 1'b0;
      a_frames   <= '0;
      b_frames   <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= accept_last;
      if (fifo_write) begin
        if (byte_cnt == LEN_MAX)
          overflow <= 1'b1;
        byte_cnt <= accept_last ? '0 : cnt_inc;
      end
      if (accept_last) begin
        last_grant <= src_is_b;
        done_port  <= src_is_b;
        done_len   <= cnt_inc;
        if (src_is_b)
          b_frames <= b_frames + CNT_W'(1);
        else
          a_frames <= a_frames + CNT_W'(1);
      end
    end
  end

endmodule
